// File: rtl/ram_port_responder_if.sv
// ram_port_responder_if: user-side DDR2 wrapper port bundle (address/data/strobes/read handshake/status).
interface ram_port_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 26
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              write_enable;
  logic              read_request;
  logic              read_ack;
  logic [DATA_W-1:0] data_out;
  logic              rdy;
  logic              rd_data_pres;
  logic [ADDR_W-1:0] max_ram_address;
  logic              addr_err;
  modport master (
    output address, data_in, write_enable, read_request, read_ack,
    input  data_out, rdy, rd_data_pres, max_ram_address, addr_err
  );
  modport slave (
    input  address, data_in, write_enable, read_request, read_ack,
    output data_out, rdy, rd_data_pres, max_ram_address, addr_err
  );
endinterface

// File: rtl/ram_port_responder.sv
// ram_port_responder: BRAM-backed stand-in for the DDR2 controller user port with calibration delay and fixed read latency.
// Define RAM_CLEAR_EN to zero the whole array after calibration, before rdy rises.
module ram_port_responder #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 26,
  parameter int DEPTH_W      = 8,
  parameter int INIT_CYCLES  = 16,
  parameter int READ_LATENCY = 4
) (
  input logic systemCLK,
  input logic reset,
  ram_port_responder_if.slave bus
);
  localparam int CW = $clog2(INIT_CYCLES + 1);
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'((2 ** DEPTH_W) - 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
  localparam logic [LW-1:0] LAT_START = LW'(READ_LATENCY - 1);
  typedef enum logic [2:0] {INIT, CLEAR, IDLE, READ_WAIT, DATA_VALID} state_t;
  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [LW-1:0]       lat_q;
  logic [DEPTH_W-1:0]  raddr_q;
  logic                oob_q;
  logic                rdy_q;
  logic                pres_q;
  logic [DATA_W-1:0]   dout_q;
  logic                err_q;
  logic [DATA_W-1:0]   mem [2 ** DEPTH_W];
  logic                in_range;
  logic                mem_we_d;
  logic [DEPTH_W-1:0]  mem_wa_d;
  logic [DATA_W-1:0]   mem_wd_d;
  assign in_range = bus.address <= MAX_ADDR;
`ifdef RAM_CLEAR_EN
  logic [DEPTH_W-1:0] clr_q;
  always_comb begin
    mem_we_d = !reset && ((state_q == CLEAR) || (state_q == IDLE && bus.write_enable && in_range));
    mem_wa_d = state_q == CLEAR ? clr_q : bus.address[DEPTH_W-1:0];
    mem_wd_d = state_q == CLEAR ? '0 : bus.data_in;
  end
`else
  always_comb begin
    mem_we_d = !reset && state_q == IDLE && bus.write_enable && in_range;
    mem_wa_d = bus.address[DEPTH_W-1:0];
    mem_wd_d = bus.data_in;
  end
`endif
  always_ff @(posedge systemCLK)
    if (mem_we_d) mem[mem_wa_d] <= mem_wd_d;
  // The array is only written in IDLE, so a read issued alongside a write sees the new data.
  always_ff @(posedge systemCLK) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      lat_q   <= '0;
      raddr_q <= '0;
      oob_q   <= 1'b0;
      rdy_q   <= 1'b0;
      pres_q  <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
`ifdef RAM_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      case (state_q)
        INIT: begin
          if (cnt_q == INIT_LAST) begin
`ifdef RAM_CLEAR_EN
            state_q <= CLEAR;
`else
            state_q <= IDLE;
            rdy_q   <= 1'b1;
`endif
          end else cnt_q <= cnt_q + 1'b1;
        end
`ifdef RAM_CLEAR_EN
        CLEAR: begin
          clr_q <= clr_q + 1'b1;
          if (&clr_q) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end
        end
`endif
        IDLE: begin
          if ((bus.write_enable || bus.read_request) && !in_range) err_q <= 1'b1;
          if (bus.read_request) begin
            raddr_q <= bus.address[DEPTH_W-1:0];
            oob_q   <= !in_range;
            lat_q   <= LAT_START;
            state_q <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (lat_q == '0) begin
            dout_q  <= oob_q ? '0 : mem[raddr_q];
            pres_q  <= 1'b1;
            state_q <= DATA_VALID;
          end else lat_q <= lat_q - 1'b1;
        end
        DATA_VALID: begin
          if (bus.read_ack) begin
            pres_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end
  assign bus.data_out        = dout_q;
  assign bus.rdy             = rdy_q;
  assign bus.rd_data_pres    = pres_q;
  assign bus.addr_err        = err_q;
  assign bus.max_ram_address = MAX_ADDR;
endmodule
